// File: rtl/sdram_wb_frontend_if.sv
// sdram_wb_frontend_if: bundles the Wishbone B4 slave bus, the command
// channel to the SDRAM core and the response channel back from it.
// The slave modport is the front-end's view. The master modport is the
// view of whatever drives both the bus and the core (a bench, or glue logic).
//
// Handshakes:
//   - Wishbone: a request transfers on a cycle with cyc_i && stb_i && !stall_o.
//     There is one ack_o per transferred request, in order.
//   - Command: the core takes the head command on a cycle with
//     cmd_valid_o && cmd_accept_i. cmd_* stays stable while it is not taken.
//   - Response: resp_valid_i is a single-cycle completion, one per command,
//     in command order. It has no back-pressure.
interface sdram_wb_frontend_if;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [3:0]  sel_i;
    logic [2:0]  cti_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic        ack_o;
    logic        stall_o;
    logic        cmd_valid_o;
    logic        cmd_accept_i;
    logic [31:0] cmd_addr_o;
    logic [31:0] cmd_data_o;
    logic [3:0]  cmd_mask_o;
    logic        cmd_we_o;
    logic        cmd_last_o;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;
    // Debug visibility of the outstanding-request counter.
    logic [7:0]  dbg_out_cnt;

    modport slave (
        input  addr_i, data_i, sel_i, cti_i, cyc_i, stb_i, we_i,
        input  cmd_accept_i, resp_valid_i, resp_data_i,
        output data_o, ack_o, stall_o,
        output cmd_valid_o, cmd_addr_o, cmd_data_o, cmd_mask_o, cmd_we_o, cmd_last_o,
        output dbg_out_cnt
    );

    modport master (
        output addr_i, data_i, sel_i, cti_i, cyc_i, stb_i, we_i,
        output cmd_accept_i, resp_valid_i, resp_data_i,
        input  data_o, ack_o, stall_o,
        input  cmd_valid_o, cmd_addr_o, cmd_data_o, cmd_mask_o, cmd_we_o, cmd_last_o,
        input  dbg_out_cnt
    );
endinterface

// File: rtl/sdram_wb_frontend.sv
// sdram_wb_frontend: pipelined Wishbone B4 slave front-end for the SDRAM core.
// Accepted requests are queued in a CMD_DEPTH-entry command FIFO and issued
// to the core one at a time. Each response pops a read/write tag FIFO, so
// that write acks return zero data. stall_o depends only on registered
// state: FIFO occupancy and the outstanding-request count.
//
// Build option: define SDRAM_WB_FE_RESP_REG_EN to register ack_o/data_o.
// This adds one cycle of response latency. Without it, the response path
// is combinational.
module sdram_wb_frontend #(
    parameter int CMD_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sdram_wb_frontend_if.slave   bus
);
    localparam int         CW        = $clog2(CMD_DEPTH);
    localparam int         TW        = $clog2(MAX_OUTSTANDING);
    localparam logic [CW:0] FIFO_FULL = (CW+1)'(CMD_DEPTH);
    localparam logic [7:0] MAX_OUT   = 8'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

    // Command FIFO storage. It is not reset: the entries are only ever
    // read while the occupancy count says they are live.
    logic [29:0] addr_mem [CMD_DEPTH];
    logic [31:0] data_mem [CMD_DEPTH];
    logic [3:0]  mask_mem [CMD_DEPTH];
    logic        we_mem   [CMD_DEPTH];
    logic        last_mem [CMD_DEPTH];
    logic [CW-1:0] wr_ptr, rd_ptr;
    logic [CW:0]   fifo_cnt;

    // Tag FIFO holds the we bit of every outstanding request, in order.
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [TW-1:0] tag_wr, tag_rd;
    logic [7:0]    tag_cnt;

    logic [7:0] out_cnt;

    logic fifo_full, fifo_empty, stall, accept, pop;
    logic rsp_take, rsp_is_read, ack_now, ack_dec;
    logic [31:0] data_now;
    logic addr_lsb_unused;

    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    // Registered state only, so there is no input-to-stall combinational path.
    assign stall      = fifo_full || (out_cnt == MAX_OUT);
    assign accept     = bus.cyc_i && bus.stb_i && !stall;
    assign pop        = !fifo_empty && bus.cmd_accept_i;

    // A response with nothing outstanding is a core protocol error. It is
    // dropped here, which also keeps the counters from underflowing.
    assign rsp_take    = bus.resp_valid_i && (tag_cnt != 8'd0);
    assign rsp_is_read = !tag_mem[tag_rd];
    assign ack_now     = rsp_take && bus.cyc_i;
    assign data_now    = (ack_now && rsp_is_read) ? bus.resp_data_i : 32'd0;

    // Address bits [1:0] are deliberately ignored.
    assign addr_lsb_unused = ^bus.addr_i[1:0];

`ifdef SDRAM_WB_FE_RESP_REG_EN
    logic        ack_q;
    logic        done_q;
    logic [31:0] data_q;

    // Response register stage. done_q marks a consumed response even when
    // it was not acked because cyc_i was low, so out_cnt still drains.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            data_q <= 32'd0;
        end else begin
            ack_q  <= ack_now;
            done_q <= rsp_take;
            data_q <= data_now;
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.data_o = data_q;
    assign ack_dec    = done_q;
`else
    assign bus.ack_o  = ack_now;
    assign bus.data_o = data_now;
    assign ack_dec    = rsp_take;
`endif

    // Command FIFO payload write on acceptance. Read data is zeroed here,
    // so the head entry can drive cmd_data_o directly.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_mem[wr_ptr] <= bus.addr_i[31:2];
            data_mem[wr_ptr] <= bus.we_i ? bus.data_i : 32'd0;
            mask_mem[wr_ptr] <= bus.sel_i;
            we_mem[wr_ptr]   <= bus.we_i;
            last_mem[wr_ptr] <= (bus.cti_i != 3'b010);
        end
    end

    // Command FIFO pointers and occupancy. The pointers wrap naturally
    // because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Tag FIFO payload: remember whether each accepted request was a write.
    always_ff @(posedge clk_i) begin
        if (accept) tag_mem[tag_wr] <= bus.we_i;
    end

    // Tag FIFO pointers and count. The depth need not be a power of two,
    // so the pointers wrap explicitly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= 8'd0;
        end else begin
            if (accept)   tag_wr <= (tag_wr == TAG_LAST) ? '0 : tag_wr + 1'b1;
            if (rsp_take) tag_rd <= (tag_rd == TAG_LAST) ? '0 : tag_rd + 1'b1;
            case ({accept, rsp_take})
                2'b10:   tag_cnt <= tag_cnt + 8'd1;
                2'b01:   tag_cnt <= tag_cnt - 8'd1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Outstanding-request count. It rises on accept and falls when a
    // response reaches the ack stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt <= 8'd0;
        end else begin
            case ({accept, ack_dec})
                2'b10:   out_cnt <= out_cnt + 8'd1;
                2'b01:   out_cnt <= out_cnt - 8'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // The head entry drives the core. Outputs read zero while the FIFO is
    // empty, so their reset value is clean.
    assign bus.stall_o     = stall;
    assign bus.cmd_valid_o = !fifo_empty;
    assign bus.cmd_addr_o  = fifo_empty ? 32'd0 : {addr_mem[rd_ptr], 2'b00};
    assign bus.cmd_data_o  = fifo_empty ? 32'd0 : data_mem[rd_ptr];
    assign bus.cmd_mask_o  = fifo_empty ? 4'd0  : mask_mem[rd_ptr];
    assign bus.cmd_we_o    = fifo_empty ? 1'b0  : we_mem[rd_ptr];
    assign bus.cmd_last_o  = fifo_empty ? 1'b0  : last_mem[rd_ptr];
    assign bus.dbg_out_cnt = out_cnt;
endmodule

// File: tb/tb_sdram_wb_frontend.sv
// tb_sdram_wb_frontend: directed bench for sdram_wb_frontend with
// CMD_DEPTH=4 and MAX_OUTSTANDING=8. Inputs change 1 ns after a rising
// edge. Outputs are checked 1 ns after that.
module tb_sdram_wb_frontend;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sdram_wb_frontend_if bus();

    sdram_wb_frontend #(.CMD_DEPTH(4), .MAX_OUTSTANDING(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [2:0] cti, input logic we);
        bus.cyc_i  = 1'b1;
        bus.stb_i  = 1'b1;
        bus.addr_i = a;
        bus.data_i = d;
        bus.sel_i  = s;
        bus.cti_i  = cti;
        bus.we_i   = we;
    endtask

    task automatic drive_beat(input int i);
        drive_req(32'h0000_0400 + 32'(i * 4), 32'h0000_1000 + 32'(i), 4'hF,
                  (i < 7) ? 3'b010 : 3'b111, 1'b1);
    endtask

    // One core response. exp_d is the data_o value the bus must see with the ack.
    task automatic resp_one(input logic [31:0] rd, input logic [31:0] exp_d, input string tag);
        bus.resp_valid_i = 1'b1;
        bus.resp_data_i  = rd;
        settle();
`ifdef SDRAM_WB_FE_RESP_REG_EN
        chk_b({tag, "_ack_early"}, bus.ack_o, 1'b0);
        tick();
        bus.resp_valid_i = 1'b0;
        bus.resp_data_i  = 32'd0;
        settle();
        chk_b({tag, "_ack"}, bus.ack_o, 1'b1);
        chk({tag, "_data"}, bus.data_o, exp_d);
        tick();
        settle();
        chk_b({tag, "_ack_end"}, bus.ack_o, 1'b0);
`else
        chk_b({tag, "_ack"}, bus.ack_o, 1'b1);
        chk({tag, "_data"}, bus.data_o, exp_d);
        tick();
        bus.resp_valid_i = 1'b0;
        bus.resp_data_i  = 32'd0;
        settle();
        chk_b({tag, "_ack_end"}, bus.ack_o, 1'b0);
`endif
    endtask

    initial begin
        int np;
        int nb;
        int acc;

        rst = 1'b1;
        bus.addr_i = 32'd0; bus.data_i = 32'd0; bus.sel_i = 4'd0; bus.cti_i = 3'd0;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.cmd_accept_i = 1'b0; bus.resp_valid_i = 1'b0; bus.resp_data_i = 32'd0;

        // Reset state
        tick();
        tick();
        settle();
        chk_b("rst_ack", bus.ack_o, 1'b0);
        chk("rst_data", bus.data_o, 32'd0);
        chk_b("rst_stall", bus.stall_o, 1'b0);
        chk_b("rst_cmd_valid", bus.cmd_valid_o, 1'b0);
        chk("rst_cmd_addr", bus.cmd_addr_o, 32'd0);
        chk("rst_cmd_data", bus.cmd_data_o, 32'd0);
        chk("rst_cmd_mask", 32'(bus.cmd_mask_o), 32'd0);
        chk_b("rst_cmd_we", bus.cmd_we_o, 1'b0);
        chk_b("rst_cmd_last", bus.cmd_last_o, 1'b0);
        chk("rst_out_cnt", 32'(bus.dbg_out_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Single write, core accepts immediately
        bus.cmd_accept_i = 1'b1;
        drive_req(32'h0000_0103, 32'hDEAD_BEEF, 4'h5, 3'b000, 1'b1);
        settle();
        chk_b("single_stall", bus.stall_o, 1'b0);
        tick();
        bus.stb_i = 1'b0;
        settle();
        chk_b("single_valid", bus.cmd_valid_o, 1'b1);
        chk("single_addr", bus.cmd_addr_o, 32'h0000_0100);
        chk("single_data", bus.cmd_data_o, 32'hDEAD_BEEF);
        chk("single_mask", 32'(bus.cmd_mask_o), 32'h5);
        chk_b("single_we", bus.cmd_we_o, 1'b1);
        chk_b("single_last", bus.cmd_last_o, 1'b1);
        chk("single_out_cnt", 32'(bus.dbg_out_cnt), 32'd1);
        tick();
        settle();
        chk_b("single_popped", bus.cmd_valid_o, 1'b0);
        resp_one(32'hAAAA_5555, 32'd0, "single");
        chk("single_out_cnt_done", 32'(bus.dbg_out_cnt), 32'd0);

        // 8-beat burst with the core holding off
        bus.cmd_accept_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_beat(i);
            settle();
            chk_b("burst_stall_open", bus.stall_o, 1'b0);
            tick();
        end
        drive_beat(4);
        settle();
        chk_b("burst_full_stall", bus.stall_o, 1'b1);
        chk("burst_head_addr", bus.cmd_addr_o, 32'h0000_0400);
        chk_b("burst_head_last", bus.cmd_last_o, 1'b0);
        chk("burst_out_cnt4", 32'(bus.dbg_out_cnt), 32'd4);
        bus.cmd_accept_i = 1'b1;
        settle();
        chk_b("full_pop_stall", bus.stall_o, 1'b1);
        np = 0;
        nb = 4;
        for (int c = 0; c < 20 && np < 8; c++) begin
            if (bus.cmd_valid_o) begin
                chk("burst_addr", bus.cmd_addr_o, 32'h0000_0400 + 32'(np * 4));
                chk("burst_data", bus.cmd_data_o, 32'h0000_1000 + 32'(np));
                chk_b("burst_last", bus.cmd_last_o, (np == 7));
                np++;
            end
            if (bus.stb_i && !bus.stall_o) nb++;
            tick();
            if (nb < 8) drive_beat(nb);
            else bus.stb_i = 1'b0;
            settle();
        end
        chk("burst_pops", 32'(np), 32'd8);
        chk_b("burst_drained", bus.cmd_valid_o, 1'b0);
        chk("burst_out_cnt8", 32'(bus.dbg_out_cnt), 32'd8);
        chk_b("burst_out_stall", bus.stall_o, 1'b1);
        for (int i = 0; i < 8; i++) resp_one(32'hABCD_0000 + 32'(i), 32'd0, "burst_resp");
        chk("burst_out_cnt0", 32'(bus.dbg_out_cnt), 32'd0);

        // Core never responds: outstanding limit throttles the bus
        drive_req(32'h0000_0800, 32'h0000_0077, 4'hF, 3'b000, 1'b1);
        settle();
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            if (!bus.stall_o) acc++;
            tick();
        end
        chk("limit_accepts", 32'(acc), 32'd8);
        chk_b("limit_stall", bus.stall_o, 1'b1);
        chk("limit_out_cnt", 32'(bus.dbg_out_cnt), 32'd8);

        // Response arrives at the limit while a request is still presented
        bus.resp_valid_i = 1'b1;
        bus.resp_data_i  = 32'd0;
        settle();
        chk_b("same_cycle_stall", bus.stall_o, 1'b1);
        chk("same_cycle_out_cnt", 32'(bus.dbg_out_cnt), 32'd8);
`ifndef SDRAM_WB_FE_RESP_REG_EN
        chk_b("same_cycle_ack", bus.ack_o, 1'b1);
`endif
        tick();
        bus.resp_valid_i = 1'b0;
`ifdef SDRAM_WB_FE_RESP_REG_EN
        settle();
        chk_b("same_cycle_ack_reg", bus.ack_o, 1'b1);
        chk_b("same_cycle_stall_reg", bus.stall_o, 1'b1);
        tick();
`endif
        settle();
        chk_b("stall_release", bus.stall_o, 1'b0);
        chk("release_out_cnt", 32'(bus.dbg_out_cnt), 32'd7);
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (!bus.stall_o) acc++;
            tick();
        end
        chk("one_more_accept", 32'(acc), 32'd1);
        chk_b("relimit_stall", bus.stall_o, 1'b1);
        chk("relimit_out_cnt", 32'(bus.dbg_out_cnt), 32'd8);
        bus.stb_i = 1'b0;
        for (int i = 0; i < 8; i++) resp_one(32'h0BAD_0000 + 32'(i), 32'd0, "limit_resp");
        chk("limit_out_cnt0", 32'(bus.dbg_out_cnt), 32'd0);

        // Write then read of the same word; the core echoes the data
        drive_req(32'h0000_0200, 32'h1234_5678, 4'hF, 3'b000, 1'b1);
        tick();
        drive_req(32'h0000_0200, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b0);
        settle();
        chk_b("wr_cmd_we", bus.cmd_we_o, 1'b1);
        chk("wr_cmd_data", bus.cmd_data_o, 32'h1234_5678);
        tick();
        bus.stb_i = 1'b0;
        settle();
        chk_b("rd_cmd_valid", bus.cmd_valid_o, 1'b1);
        chk_b("rd_cmd_we", bus.cmd_we_o, 1'b0);
        chk("rd_cmd_data", bus.cmd_data_o, 32'd0);
        chk("rd_cmd_addr", bus.cmd_addr_o, 32'h0000_0200);
        tick();
        resp_one(32'h55AA_55AA, 32'd0, "wr_resp");
        resp_one(32'h1234_5678, 32'h1234_5678, "rd_resp");
        chk("wr_rd_out_cnt", 32'(bus.dbg_out_cnt), 32'd0);

        // Response while cyc_i is low is consumed without an ack
        drive_req(32'h0000_0300, 32'd0, 4'hF, 3'b000, 1'b0);
        tick();
        bus.stb_i = 1'b0;
        bus.cyc_i = 1'b0;
        bus.resp_valid_i = 1'b1;
        bus.resp_data_i  = 32'hCAFE_F00D;
        settle();
        chk_b("silent_ack", bus.ack_o, 1'b0);
        tick();
        bus.resp_valid_i = 1'b0;
        bus.resp_data_i  = 32'd0;
`ifdef SDRAM_WB_FE_RESP_REG_EN
        settle();
        chk_b("silent_ack_reg", bus.ack_o, 1'b0);
        chk("silent_data_reg", bus.data_o, 32'd0);
        tick();
`endif
        settle();
        chk("silent_out_cnt", 32'(bus.dbg_out_cnt), 32'd0);
        bus.cyc_i = 1'b1;

        // Stray response with nothing outstanding is ignored
        bus.resp_valid_i = 1'b1;
        bus.resp_data_i  = 32'h1111_2222;
        settle();
        chk_b("stray_ack", bus.ack_o, 1'b0);
        tick();
        bus.resp_valid_i = 1'b0;
        tick();
        tick();
        chk("stray_out_cnt", 32'(bus.dbg_out_cnt), 32'd0);
        chk_b("stray_stall", bus.stall_o, 1'b0);

        // Reset with three queued commands
        bus.cmd_accept_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(32'h0000_0500 + 32'(i * 4), 32'h0000_00A0 + 32'(i), 4'hF, 3'b000, 1'b1);
            tick();
        end
        bus.stb_i = 1'b0;
        settle();
        chk_b("pre_rst_valid", bus.cmd_valid_o, 1'b1);
        chk("pre_rst_out_cnt", 32'(bus.dbg_out_cnt), 32'd3);
        rst = 1'b1;
        tick();
        settle();
        chk_b("mid_rst_valid", bus.cmd_valid_o, 1'b0);
        chk_b("mid_rst_stall", bus.stall_o, 1'b0);
        chk_b("mid_rst_ack", bus.ack_o, 1'b0);
        chk("mid_rst_addr", bus.cmd_addr_o, 32'd0);
        chk("mid_rst_out_cnt", 32'(bus.dbg_out_cnt), 32'd0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
